// File: rtl/mem_arbiter_pkg.sv
// Shared CPU/RAM types for the memory arbiter: data word and RAM handshake state,
// plus the width of the wait counter.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int CNT_W = 5;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request bundle and RAM-side port bundle for the memory arbiter.
// Master drives requests/strobes, slave responds.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t iload;
  word_t dload;
  logic  ihit;
  logic  dhit;
  logic  merr;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iload, dload, ihit, dhit, merr
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output iload, dload, ihit, dhit, merr
  );
endinterface

interface cpu_ram_if;
  import mem_arbiter_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serializes instruction fetches and data loads/stores,
// data first, answering each with a one-cycle hit pulse and a registered word.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  cif,
  cpu_ram_if.master     rif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DREQ   = 3'd1,
    IREQ   = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  word_t            r_iload;
  word_t            r_dload;
  logic             r_ihit;
  logic             r_dhit;
  logic             r_merr;

  logic  w_access;
  logic  w_abort;
  logic  w_busyState;
  logic  w_ramREN;
  logic  w_ramWEN;
  word_t w_ramaddr;
  word_t w_ramstore;

  assign w_access    = (rif.ramstate == ACCESS);
  assign w_abort     = (rif.ramstate == ERROR) || (r_count == CNT_W'(TIMEOUT));
  assign w_busyState = (r_state == DREQ) || (r_state == IREQ);

  // A real ACCESS always wins over an abort arriving in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_ramREN    = 1'b0;
    w_ramWEN    = 1'b0;
    w_ramaddr   = '0;
    w_ramstore  = '0;
    case (r_state)
      IDLE: begin
        if (cif.dREN || cif.dWEN) begin
          w_nextState = DREQ;
        end else if (cif.iREN) begin
          w_nextState = IREQ;
        end
      end
      DREQ: begin
        w_ramaddr  = cif.daddr;
        w_ramREN   = cif.dREN;
        w_ramWEN   = cif.dWEN;
        w_ramstore = cif.dstore;
        if (w_access || w_abort) begin
          w_nextState = DONE_D;
        end
      end
      IREQ: begin
        w_ramaddr = cif.iaddr;
        w_ramREN  = 1'b1;
        if (w_access || w_abort) begin
          w_nextState = DONE_I;
        end
      end
      DONE_D:  w_nextState = IDLE;
      DONE_I:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_count <= '0;
      r_iload <= '0;
      r_dload <= '0;
      r_ihit  <= 1'b0;
      r_dhit  <= 1'b0;
      r_merr  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ihit  <= (w_nextState == DONE_I);
      r_dhit  <= (w_nextState == DONE_D);
      if (r_state == IDLE) begin
        r_count <= '0;
      end else if (w_busyState && !w_access) begin
        r_count <= r_count + 1'b1;
      end
      if ((r_state == DREQ) && w_access && cif.dREN) begin
        r_dload <= rif.ramload;
      end
      if ((r_state == IREQ) && w_access) begin
        r_iload <= rif.ramload;
      end
      // Sticky until reset; the hit is still issued so no requester deadlocks.
      if (w_busyState && !w_access && w_abort) begin
        r_merr <= 1'b1;
      end
    end
  end

  assign cif.iload    = r_iload;
  assign cif.dload    = r_dload;
  assign cif.ihit     = r_ihit;
  assign cif.dhit     = r_dhit;
  assign cif.merr     = r_merr;
  assign rif.ramREN   = w_ramREN;
  assign rif.ramWEN   = w_ramWEN;
  assign rif.ramaddr  = w_ramaddr;
  assign rif.ramstore = w_ramstore;

endmodule
